// File: rtl/m6809_bus_master.sv
// Card-bus initiator: byte command stream in, one bus cycle, one response byte out.
// Optional wait-state abort is compiled in with BUS_TIMEOUT_EN.
module m6809_bus_master #(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 2,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [7:0]  cmd_byte,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  rsp_byte,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] adr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        rd_b,
  output logic        wr_b,
  output logic        mreq_b,
  output logic        ioreq_b,
  input  logic        wait_b
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AHI,
    S_ALO,
    S_DATA,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_t;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  state_t     state;
  state_t     state_n;
  logic [3:0] phase;
  logic       op_wr;
  logic       op_io;
  logic [7:0] adr_hi;
  logic [7:0] adr_lo;
  logic       xfer;
  logic       bad_op;
  logic       bus_act;
  logic       strobe_min;
  logic       tmo;

  assign xfer       = cmd_valid & cmd_ready;
  assign bad_op     = |cmd_byte[7:2];
  assign strobe_min = phase >= 4'(STROBE_CYC - 1);

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  logic [TW-1:0] tcnt;

  // Counts wait-low cycles of the current strobe; zero outside STROBE.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      tcnt <= '0;
    end else if (state != S_STROBE) begin
      tcnt <= '0;
    end else if (!wait_b) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign tmo = !wait_b && (tcnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (xfer) state_n = bad_op ? S_RESP : S_AHI;
      end
      S_AHI: begin
        if (xfer) state_n = S_ALO;
      end
      S_ALO: begin
        if (xfer) state_n = op_wr ? S_DATA : S_SETUP;
      end
      S_DATA: begin
        if (xfer) state_n = S_SETUP;
      end
      S_SETUP: begin
        if (phase == 4'(SETUP_CYC - 1)) state_n = S_STROBE;
      end
      S_STROBE: begin
        if (tmo || (strobe_min && wait_b)) state_n = S_HOLD;
      end
      S_HOLD: begin
        if (phase == 4'(HOLD_CYC - 1)) state_n = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Cycles spent in the current state, saturating.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      phase <= '0;
    end else if (state_n != state) begin
      phase <= '0;
    end else if (phase != 4'hF) begin
      phase <= phase + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      op_wr    <= 1'b0;
      op_io    <= 1'b0;
      adr_hi   <= 8'h00;
      adr_lo   <= 8'h00;
      adr      <= 16'h0000;
      data_out <= 8'h00;
      rsp_byte <= 8'h00;
    end else begin
      if (state == S_IDLE && xfer) begin
        op_wr <= cmd_byte[0];
        op_io <= cmd_byte[1];
        if (bad_op) rsp_byte <= NAK;
      end
      if (state == S_AHI && xfer) adr_hi <= cmd_byte;
      if (state == S_ALO && xfer) begin
        adr_lo <= cmd_byte;
        if (!op_wr) adr <= {adr_hi, cmd_byte};
      end
      if (state == S_DATA && xfer) begin
        adr      <= {adr_hi, adr_lo};
        data_out <= cmd_byte;
      end
      if (state == S_STROBE && state_n == S_HOLD) begin
        if (tmo) rsp_byte <= NAK;
        else if (op_wr) rsp_byte <= ACK;
        else rsp_byte <= data_in;
      end
    end
  end

  assign bus_act = (state == S_SETUP) || (state == S_STROBE) ||
                   (state == S_HOLD);

  assign mreq_b    = !(bus_act && !op_io);
  assign ioreq_b   = !(bus_act && op_io);
  assign rd_b      = !(state == S_STROBE && !op_wr);
  assign wr_b      = !(state == S_STROBE && op_wr);
  assign data_oe   = bus_act && op_wr;
  assign rsp_valid = (state == S_RESP);
  assign cmd_ready = reset_b &&
                     ((state == S_IDLE) || (state == S_AHI) ||
                      (state == S_ALO) || (state == S_DATA));

endmodule

// File: tb/tb_m6809_bus_master.sv
// Bench for m6809_bus_master: directed and random command frames
// checked against a frame-level model of bus timing and responses.
module tb_m6809_bus_master;

  localparam int SETUP  = 2;
  localparam int STROBE = 2;
  localparam int HOLD   = 1;
  localparam int TMO    = 1024;

  logic        clk;
  logic        reset_b;
  logic [7:0]  cmd_byte;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  rsp_byte;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] adr;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  data_in;
  logic        rd_b;
  logic        wr_b;
  logic        mreq_b;
  logic        ioreq_b;
  logic        wait_b;

  int checks;
  int passes;
  int fails;
  int stall;

  m6809_bus_master #(
    .SETUP_CYC   (SETUP),
    .STROBE_CYC  (STROBE),
    .HOLD_CYC    (HOLD),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .cmd_byte  (cmd_byte),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .rsp_byte  (rsp_byte),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .adr       (adr),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .data_in   (data_in),
    .rd_b      (rd_b),
    .wr_b      (wr_b),
    .mreq_b    (mreq_b),
    .ioreq_b   (ioreq_b),
    .wait_b    (wait_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    cmd_byte  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) stall++;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // One frame: drive it, watch the bus, check against the frame model.
  task automatic run_txn(input string tag, input logic [7:0] op,
                         input logic [15:0] a, input logic [7:0] d,
                         input int w, input logic [7:0] din,
                         input int delay);
    bit valid, wr, io, tmo_hit;
    int strb, sel;
    int mc, ic, rc, wc, oc, k, cyc, viol, bp_bad;
    logic [15:0] adr_s;
    logic [7:0]  dout_s, rsp_s, exp_rsp;
    valid = (op[7:2] == 6'd0);
    wr = op[0];
    io = op[1];
`ifdef BUS_TIMEOUT_EN
    tmo_hit = (w >= TMO);
`else
    tmo_hit = 1'b0;
`endif
    strb = tmo_hit ? TMO : ((w + 1 > STROBE) ? w + 1 : STROBE);
    sel = valid ? SETUP + strb + HOLD : 0;
    if (!valid || tmo_hit) exp_rsp = 8'h15;
    else if (wr) exp_rsp = 8'h06;
    else exp_rsp = din;

    mc = 0; ic = 0; rc = 0; wc = 0; oc = 0;
    k = 0; cyc = 0; viol = 0; bp_bad = 0;
    adr_s = 16'hxxxx;
    dout_s = 8'hxx;
    stall = 0;
    data_in = din;
    wait_b = 1'b1;
    rsp_ready = (delay == 0);

    send_byte(op);
    if (valid) begin
      send_byte(a[15:8]);
      send_byte(a[7:0]);
      if (wr) send_byte(d);
    end

    while (cyc < w + 200) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (!mreq_b) mc++;
      if (!ioreq_b) ic++;
      if (!rd_b) rc++;
      if (!wr_b) wc++;
      if (data_oe) oc++;
      if (!rd_b && !wr_b) viol++;
      if (!mreq_b && !ioreq_b) viol++;
      if (!rd_b || !wr_b) begin
        if (mreq_b == ioreq_b) viol++;
        adr_s = adr;
        dout_s = data_out;
        k++;
        wait_b = (k > w);
      end else begin
        wait_b = 1'b1;
      end
      cyc++;
    end

    chk({tag, ":stall"}, stall, 0);
    chk({tag, ":rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, ":rsp"}, rsp_byte, exp_rsp);
    chk({tag, ":mreq_cyc"}, mc, (valid && !io) ? sel : 0);
    chk({tag, ":ioreq_cyc"}, ic, (valid && io) ? sel : 0);
    chk({tag, ":rd_cyc"}, rc, (valid && !wr) ? strb : 0);
    chk({tag, ":wr_cyc"}, wc, (valid && wr) ? strb : 0);
    chk({tag, ":oe_cyc"}, oc, (valid && wr) ? sel : 0);
    chk({tag, ":bus_rules"}, viol, 0);
    if (valid) chk({tag, ":adr"}, adr_s, a);
    if (valid && wr) chk({tag, ":data_out"}, dout_s, d);

    rsp_s = rsp_byte;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_byte !== rsp_s || cmd_ready) bp_bad++;
    end
    if (delay > 0) chk({tag, ":backpressure"}, bp_bad, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, ":idle_after"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    int seen;
    int late;
    logic [7:0] op;
    checks = 0; passes = 0; fails = 0; stall = 0;
    reset_b = 1'b0;
    cmd_byte = 8'h00;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    data_in = 8'h00;
    wait_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:cmd_ready", cmd_ready, 1'b0);
    chk("rst:rsp", {rsp_valid, rsp_byte}, 9'h000);
    chk("rst:adr", adr, 16'h0000);
    chk("rst:data", {data_oe, data_out}, 9'h000);
    chk("rst:strobes", {rd_b, wr_b, mreq_b, ioreq_b}, 4'hF);
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    chk("idle:cmd_ready", cmd_ready, 1'b1);

    run_txn("rd_mem", 8'h00, 16'hA000, 8'h00, 0, 8'h5A, 1);
    run_txn("wr_io", 8'h03, 16'h0042, 8'hC3, 0, 8'h00, 2);
    run_txn("rd_wait", 8'h00, 16'h1234, 8'h00, 7, 8'hA7, 0);
    run_txn("bad_op", 8'h80, 16'h0000, 8'h00, 0, 8'h00, 1);
    run_txn("after_bad", 8'h01, 16'h8001, 8'h3C, 0, 8'h00, 0);
    run_txn("rd_io", 8'h02, 16'hFFFF, 8'h00, 1, 8'h81, 10);
    run_txn("wr_wait", 8'h01, 16'h0000, 8'hFF, 3, 8'h00, 3);

    // Abort mid-strobe with the target holding wait low.
    wait_b = 1'b0;
    data_in = 8'h99;
    send_byte(8'h00);
    send_byte(8'h55);
    send_byte(8'hAA);
    seen = 0;
    while (rd_b && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    chk("mid:strobe_seen", rd_b, 1'b0);
    reset_b = 1'b0;
    @(posedge clk);
    #1;
    chk("mid:bus_idle",
        {rd_b, wr_b, mreq_b, ioreq_b, data_oe, rsp_valid}, 6'b111100);
    reset_b = 1'b1;
    wait_b = 1'b1;
    late = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || !cmd_ready) late++;
    end
    chk("mid:no_rsp", late, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0)
        op = {6'($urandom_range(1, 63)), 2'($urandom_range(0, 3))};
      else
        op = {6'd0, 2'($urandom_range(0, 3))};
      run_txn("rand", op, 16'($urandom), 8'($urandom),
              $urandom_range(0, 5), 8'($urandom),
              $urandom_range(0, 3));
    end

`ifdef BUS_TIMEOUT_EN
    run_txn("timeout", 8'h00, 16'h4000, 8'h00, 2000, 8'h11, 1);
    run_txn("post_tmo", 8'h02, 16'h0010, 8'h00, 0, 8'h22, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
